// File: rtl/uart_parity_unit.sv
// UART parity engine: registered TX parity generation plus a serial RX parity checker.
// Optional macro PARITY_ERR_CNT_EN adds the saturating err_count; otherwise err_count is tied to 0.
module uart_parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  Data_Valid,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_bit,
  output logic                  par_vld,
  input  logic                  rx_start,
  input  logic                  rx_bit_vld,
  input  logic                  rx_bit,
  output logic                  par_err,
  output logic                  par_err_sticky,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  rx_busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} rx_state_e;

  // Parity rule shared by TX and RX: even, odd, space, mark.
  function automatic logic apply_type(input logic xor_val, input logic [1:0] typ);
    case (typ)
      2'b00:   apply_type = xor_val;
      2'b01:   apply_type = ~xor_val;
      2'b10:   apply_type = 1'b0;
      default: apply_type = 1'b1;
    endcase
  endfunction

  logic            par_bit_q, par_vld_q;
  logic            tx_capture;
  logic            tx_par_d;
  rx_state_e       state_q;
  logic            acc_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [1:0]      typ_q;
  logic            par_err_q, sticky_q;
  logic            mismatch;

  assign tx_capture = Data_Valid && !busy;
  assign tx_par_d   = PAR_EN ? apply_type(^P_DATA, PAR_TYP) : 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bit_q <= 1'b0;
      par_vld_q <= 1'b0;
    end else begin
      par_vld_q <= tx_capture;
      if (tx_capture) par_bit_q <= tx_par_d;
    end
  end

  // A restart request takes priority over a parity strobe in the same cycle.
  assign mismatch = (state_q == PARITY) && rx_bit_vld && !rx_start &&
                    (rx_bit != apply_type(acc_q, typ_q));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      bit_cnt_q <= '0;
      typ_q     <= 2'b00;
      par_err_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      par_err_q <= mismatch;
      if (mismatch)     sticky_q <= 1'b1;
      else if (err_clr) sticky_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_start && PAR_EN) begin
            typ_q     <= PAR_TYP;
            acc_q     <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA, PARITY: begin
          if (rx_start) begin
            typ_q     <= PAR_TYP;
            acc_q     <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end else if (rx_bit_vld) begin
            if (state_q == DATA) begin
              acc_q     <= acc_q ^ rx_bit;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) state_q <= PARITY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mismatch) begin
      if (err_clr)             err_cnt_d = CNT_WIDTH'(1);
      else if (~&err_cnt_q)    err_cnt_d = err_cnt_q + 1'b1;
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign par_bit        = par_bit_q;
  assign par_vld        = par_vld_q;
  assign par_err        = par_err_q;
  assign par_err_sticky = sticky_q;
  assign rx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_parity_unit.sv
// Self-checking bench for uart_parity_unit; expected TX parity and RX error results
// are queued when stimulus is driven and popped when the DUT responds.
module tb_uart_parity_unit;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          PAR_EN;
  logic [1:0]    PAR_TYP;
  logic          Data_Valid;
  logic          busy;
  logic [DW-1:0] P_DATA;
  logic          par_bit, par_vld;
  logic          rx_start, rx_bit_vld, rx_bit;
  logic          par_err, par_err_sticky;
  logic          err_clr;
  logic [CW-1:0] err_count;
  logic          rx_busy;

  int testsRun = 0;
  int testsFailed = 0;

  bit txQ[$];
  bit rxQ[$];
  bit rxPending = 0;
  bit lastPar = 0;
  bit modelSticky = 0;
  int modelCount = 0;

  uart_parity_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Data_Valid(Data_Valid), .busy(busy), .P_DATA(P_DATA),
    .par_bit(par_bit), .par_vld(par_vld),
    .rx_start(rx_start), .rx_bit_vld(rx_bit_vld), .rx_bit(rx_bit),
    .par_err(par_err), .par_err_sticky(par_err_sticky), .err_clr(err_clr),
    .err_count(err_count), .rx_busy(rx_busy)
  );

  always #5 CLK = ~CLK;

  // Reference parity rule written independently of the design.
  function automatic bit refParity(input logic [DW-1:0] d, input logic [1:0] typ);
    bit x = 0;
    for (int i = 0; i < DW; i++) x = x ^ d[i];
    if (typ == 2'b00) return x;
    if (typ == 2'b01) return !x;
    if (typ == 2'b10) return 0;
    return 1;
  endfunction

  function automatic int expCount();
`ifdef PARITY_ERR_CNT_EN
    return modelCount;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock: queue TX expectation at capture, then check the registered response after the edge.
  task automatic tick();
    bit cap;
    bit expErr;
    cap = Data_Valid && !busy && !RST;
    if (cap) txQ.push_back(PAR_EN ? refParity(P_DATA, PAR_TYP) : 1'b0);
    @(posedge CLK);
    #1;
    checkOutput("par_vld", par_vld, cap);
    if (par_vld && txQ.size() > 0) begin
      lastPar = txQ.pop_front();
      checkOutput("par_bit", par_bit, lastPar);
    end
    expErr = 0;
    if (rxPending && rxQ.size() > 0) expErr = rxQ.pop_front();
    rxPending = 0;
    checkOutput("par_err", par_err, expErr);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [1:0] typ);
    Data_Valid = 1; busy = 0; P_DATA = d; PAR_EN = 1; PAR_TYP = typ;
    tick();
    Data_Valid = 0;
    tick();
  endtask

  task automatic sendFrame(input logic [DW-1:0] d, input logic [1:0] typ, input bit rxPar, input bit clr);
    bit bad;
    PAR_EN = 1; PAR_TYP = typ;
    rx_start = 1;
    tick();
    rx_start = 0;
    checkOutput("rx_busy_start", rx_busy, 1);
    for (int i = 0; i < DW; i++) begin
      rx_bit_vld = 1; rx_bit = d[i];
      tick();
    end
    bad = (rxPar != refParity(d, typ));
    rx_bit_vld = 1; rx_bit = rxPar; err_clr = clr;
    rxQ.push_back(bad);
    rxPending = 1;
    tick();
    rx_bit_vld = 0; err_clr = 0;
    if (bad) begin
      modelSticky = 1;
      modelCount = clr ? 1 : ((modelCount < 255) ? modelCount + 1 : 255);
    end else if (clr) begin
      modelSticky = 0;
      modelCount = 0;
    end
    checkOutput("rx_busy_end", rx_busy, 0);
  endtask

  task automatic checkErrState(input string tag);
    checkOutput({tag, "_sticky"}, par_err_sticky, modelSticky);
    checkOutput({tag, "_count"}, err_count, expCount());
  endtask

  initial begin
    RST = 1; PAR_EN = 0; PAR_TYP = 0; Data_Valid = 0; busy = 0; P_DATA = 0;
    rx_start = 0; rx_bit_vld = 0; rx_bit = 0; err_clr = 0;
    tick(); tick();
    checkOutput("rst_par_bit", par_bit, 0);
    checkOutput("rst_sticky", par_err_sticky, 0);
    checkOutput("rst_count", err_count, 0);
    checkOutput("rst_rx_busy", rx_busy, 0);
    RST = 0;
    tick();
    checkOutput("idle_rx_busy", rx_busy, 0);

    applyStimulus(8'hA5, 2'b00);
    applyStimulus(8'h07, 2'b00);
    applyStimulus(8'h07, 2'b01);
    applyStimulus(8'h00, 2'b11);
    applyStimulus(8'hFF, 2'b10);
    Data_Valid = 1; busy = 0; P_DATA = 8'h07; PAR_EN = 0; PAR_TYP = 2'b11;
    tick();
    Data_Valid = 0; PAR_EN = 1;
    tick();

    // Blocked capture followed by release.
    applyStimulus(8'h01, 2'b01);
    Data_Valid = 1; busy = 1; P_DATA = 8'h07; PAR_TYP = 2'b00;
    tick(); tick();
    checkOutput("par_bit_hold", par_bit, lastPar);
    busy = 0;
    tick();
    Data_Valid = 0;
    tick();
    checkOutput("par_bit_release", par_bit, 1);

    sendFrame(8'hA5, 2'b00, 0, 0);
    checkErrState("good");
    sendFrame(8'h3C, 2'b01, 1, 0);
    checkErrState("good_odd");

    sendFrame(8'h5A, 2'b11, 0, 0);
    checkErrState("bad1");
    for (int i = 0; i < 255; i++) sendFrame(DW'($urandom_range(0, 255)), 2'b11, 0, 0);
    checkErrState("sat");
    sendFrame(8'h11, 2'b10, 1, 0);
    checkErrState("sat_hold");

    err_clr = 1;
    tick();
    err_clr = 0;
    modelSticky = 0; modelCount = 0;
    checkErrState("clr");

    sendFrame(8'h0F, 2'b00, 0, 0);
    sendFrame(8'h0F, 2'b00, 1, 1);
    checkErrState("clr_vs_err");

    // Abort after three data bits, then a full good frame.
    PAR_EN = 1; PAR_TYP = 2'b00; rx_start = 1;
    tick();
    rx_start = 0;
    for (int i = 0; i < 3; i++) begin
      rx_bit_vld = 1; rx_bit = 1;
      tick();
    end
    rx_bit_vld = 0;
    sendFrame(8'hC3, 2'b00, 0, 0);
    checkErrState("abort");

    // TX and RX strobes in the same cycle.
    Data_Valid = 1; P_DATA = 8'h80; PAR_TYP = 2'b00; rx_start = 1;
    tick();
    Data_Valid = 0; rx_start = 0;
    checkOutput("tx_rx_busy", rx_busy, 1);
    tick();

    PAR_EN = 0; rx_start = 1;
    RST = 1;
    tick();
    RST = 0; rx_start = 1;
    tick();
    rx_start = 0;
    checkOutput("start_no_en", rx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
